// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and control-unit handshake bundle for fetch_unit.
interface fetch_unit_if #(parameter int ADDR_W = 10);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch;
    logic              loadPC;
    logic              ret;
    logic              push;
    logic [ADDR_W-1:0] target;
    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_rdata, imem_ack, instr_ready, branch, loadPC, ret, push, target
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_rdata, imem_ack, instr_ready, branch, loadPC, ret, push, target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, req/ack instruction fetch, valid/ready issue and circular return-address stack.
// Define FETCH_STATS_EN to add instr_count/redirect_count ports.
module fetch_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_ovf,
    output logic              ras_unf
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       instr_count,
    output logic [15:0]       redirect_count
`endif
);
    localparam int PW = $clog2(RAS_DEPTH);
    typedef enum logic [1:0] {S_RST, S_REQ, S_VALID} state_t;
    state_t            state, state_nx;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]     ptr, top_idx;
    logic [PW:0]       cnt;
    logic [15:0]       instr_q;
    logic              hs, full, empty;
    logic [ADDR_W-1:0] pc_inc, pc_nx;

    assign bus.imem_req    = state == S_REQ;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = state == S_VALID;
    assign hs      = state == S_VALID && bus.instr_ready;
    assign top_idx = ptr - PW'(1);
    assign full    = cnt == (PW+1)'(RAS_DEPTH);
    assign empty   = cnt == '0;
    assign pc_inc  = pc + ADDR_W'(1);
    // A plain ret on an empty stack falls back to RESET_PC; push+ret always uses the stored top
    assign pc_nx   = bus.ret ? ((empty && !bus.push) ? RESET_PC : ras[top_idx]) :
                     (bus.branch || bus.loadPC) ? bus.target : pc_inc;

    always_comb begin
        state_nx = state;
        if (state == S_RST)
            state_nx = S_REQ;
        else if (state == S_REQ && bus.imem_ack)
            state_nx = S_VALID;
        else if (hs)
            state_nx = S_REQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RST;
            pc      <= RESET_PC;
            instr_q <= '0;
            ptr     <= '0;
            cnt     <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_REQ && bus.imem_ack)
                instr_q <= bus.imem_rdata;
            if (hs) begin
                pc <= pc_nx;
                if (bus.push && !bus.ret) begin
                    ptr <= ptr + PW'(1);
                    if (full)
                        ras_ovf <= 1'b1;
                    else
                        cnt <= cnt + (PW+1)'(1);
                end else if (bus.ret && !bus.push) begin
                    if (empty)
                        ras_unf <= 1'b1;
                    else begin
                        ptr <= top_idx;
                        cnt <= cnt - (PW+1)'(1);
                    end
                end
            end
        end
    end

    // When full, ptr already points at the oldest entry, so a push overwrites it
    always_ff @(posedge clk) begin
        if (!rst && hs && bus.push)
            ras[bus.ret ? top_idx : ptr] <= pc_inc;
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count    <= '0;
            redirect_count <= '0;
        end else if (hs) begin
            instr_count <= instr_count + 32'd1;
            if (bus.ret || bus.branch || bus.loadPC)
                redirect_count <= redirect_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, RAS call/return, overflow/underflow, wrap and reset.
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pc;
    logic       ras_ovf, ras_unf;
    logic [9:0] a, nxt;
    int         n_checks = 0;
    int         n_fail = 0;
`ifdef FETCH_STATS_EN
    logic [31:0] instr_count;
    logic [15:0] redirect_count;
`endif

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(10)) bus ();

    fetch_unit #(.ADDR_W(10), .RAS_DEPTH(8), .RESET_PC(10'd0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .pc(pc),
        .ras_ovf(ras_ovf),
        .ras_unf(ras_unf)
`ifdef FETCH_STATS_EN
        ,
        .instr_count(instr_count),
        .redirect_count(redirect_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic b, input logic l, input logic r, input logic p, input logic [9:0] tgt);
        bus.branch = b;
        bus.loadPC = l;
        bus.ret    = r;
        bus.push   = p;
        bus.target = tgt;
    endtask

    // Serve one fetch at address a (memory returns addr+0x1000, ack in the first request cycle),
    // then hand it over with the given control decision.
    task automatic fetch(input logic [9:0] addr, input int exp_wait, input logic b, input logic l,
                         input logic r, input logic p, input logic [9:0] tgt);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", n, exp_wait);
        chk("imem_addr", {22'd0, bus.imem_addr}, {22'd0, addr});
        bus.imem_rdata = {6'd0, bus.imem_addr} + 16'h1000;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("instr", {16'd0, bus.instr}, {16'd0, {6'd0, addr} + 16'h1000});
        chk("req_drop", {31'd0, bus.imem_req}, 32'd0);
        set_ctrl(b, l, r, p, tgt);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        set_ctrl(0, 0, 0, 0, 10'd0);
        chk("valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 16'h0;
        bus.instr_ready = 1'b0;
        set_ctrl(0, 0, 0, 0, 10'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", {22'd0, pc}, 32'h0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'h0);
        chk("rst_flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
        rst = 1'b0;
        // Sequential fetch at 2-cycle spacing
        fetch(10'd0, 1, 0, 0, 0, 0, 10'd0);
        fetch(10'd1, 0, 0, 0, 0, 0, 10'd0);
        fetch(10'd2, 0, 0, 0, 0, 0, 10'd0);
        // Slow memory then backpressure
        for (int i = 0; i < 3; i++) begin
            chk("slow_req", {31'd0, bus.imem_req}, 32'd1);
            chk("slow_addr", {22'd0, bus.imem_addr}, 32'd3);
            @(negedge clk);
        end
        bus.imem_rdata = 16'h1003;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("bp_instr", {16'd0, bus.instr}, 32'h1003);
            chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk("bp_pc", {22'd0, pc}, 32'd4);
        // Call and return
        fetch(10'd4, 0, 0, 0, 0, 0, 10'd0);
        fetch(10'd5, 0, 0, 1, 0, 1, 10'h20);
        fetch(10'h20, 0, 0, 0, 0, 0, 10'd0);
        fetch(10'h21, 0, 0, 0, 0, 0, 10'd0);
        fetch(10'h22, 0, 0, 0, 1, 0, 10'd0);
        chk("call_flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
        fetch(10'd6, 0, 0, 0, 0, 0, 10'd0);
        // Nine calls overflow the 8-entry stack; the push of 8 is lost
        a = 10'd7;
        for (int i = 0; i < 9; i++) begin
            nxt = 10'h100 + 10'(i * 16);
            fetch(a, 0, 0, 1, 0, 1, nxt);
            if (i == 7) chk("ovf_pre", {31'd0, ras_ovf}, 32'd0);
            a = nxt;
        end
        chk("ovf_set", {30'd0, ras_ovf, ras_unf}, 32'd2);
        for (int k = 0; k < 8; k++) begin
            nxt = 10'h171 - 10'(k * 16);
            fetch(a, 0, 0, 0, 1, 0, 10'd0);
            chk("ret_pc", {22'd0, pc}, {22'd0, nxt});
            a = nxt;
        end
        chk("unf_pre", {31'd0, ras_unf}, 32'd0);
        fetch(10'h101, 0, 0, 0, 1, 0, 10'd0);
        chk("unf_pc", {22'd0, pc}, 32'd0);
        chk("unf_set", {30'd0, ras_ovf, ras_unf}, 32'd3);
        // Wrap, then ret beats branch
        fetch(10'd0, 0, 0, 1, 0, 0, 10'h3FF);
        fetch(10'h3FF, 0, 0, 0, 0, 0, 10'd0);
        chk("wrap_pc", {22'd0, pc}, 32'd0);
        fetch(10'd0, 0, 0, 1, 0, 0, 10'h0F);
        fetch(10'h0F, 0, 0, 1, 0, 1, 10'h30);
        fetch(10'h30, 0, 1, 0, 1, 0, 10'h40);
        chk("prio_pc", {22'd0, pc}, 32'h10);
        // push+ret swaps the top entry
        fetch(10'h10, 0, 0, 1, 0, 1, 10'h50);
        fetch(10'h50, 0, 0, 0, 1, 1, 10'd0);
        chk("swap_pc", {22'd0, pc}, 32'h11);
        fetch(10'h11, 0, 0, 0, 1, 0, 10'd0);
        chk("swap_ret", {22'd0, pc}, 32'h51);
        chk("sticky", {30'd0, ras_ovf, ras_unf}, 32'd3);
        // Reset while a request is outstanding; late ack must be ignored
        fetch(10'h51, 0, 0, 0, 0, 0, 10'd0);
        chk("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mrst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mrst_pc", {22'd0, pc}, 32'd0);
        chk("mrst_flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
        rst = 1'b0;
        bus.imem_rdata = 16'hBEEF;
        bus.imem_ack   = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("late_ack_instr", {16'd0, bus.instr}, 32'h0);
        fetch(10'd0, 0, 0, 0, 0, 0, 10'd0);
        chk("post_rst_pc", {22'd0, pc}, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit. Holds the PC and fetches 16-bit instructions from instruction memory over a req/ack handshake, then presents them to the control unit with a valid/ready handshake. Consumes the control unit's branch/loadPC/ret/push decisions to compute the next PC. Owns a circular return-address stack (RAS).

Parameters:
ADDR_W, 10, instruction address width; PC wraps modulo 2^ADDR_W
RAS_DEPTH, 8, return-address stack entries; power of two, at least 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  instruction memory read request
imem_addr  output  ADDR_W  read address; equals pc while imem_req=1
imem_rdata  input  16  read data; sampled when imem_ack=1
imem_ack  input  1  read complete
instr  output  16  instruction presented to the control unit
instr_valid  output  1  instr is valid
instr_ready  input  1  control unit consumes instr this cycle
branch  input  1  conditional branch taken (sampled at handshake)
loadPC  input  1  unconditional jump (sampled at handshake)
ret  input  1  return: pop RAS into PC (sampled at handshake)
push  input  1  call: push pc+1 onto RAS (sampled at handshake)
target  input  ADDR_W  redirect address for branch/loadPC
pc  output  ADDR_W  address of the current or pending instruction
ras_ovf  output  1  sticky: push occurred while RAS was full
ras_unf  output  1  sticky: ret occurred while RAS was empty

Behaviour:
- Reset (rst=1 at clock edge): pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, RAS empty (count=0, pointer=0), ras_ovf=0, ras_unf=0, state=S_RST.
- States: S_RST -> S_REQ unconditionally on the first clock with rst=0.
- S_REQ: imem_req=1, imem_addr=pc held stable. When imem_ack=1 (permitted in the first S_REQ cycle): instr<=imem_rdata, go to S_VALID.
- S_VALID: instr_valid=1, imem_req=0, instr held stable. When instr_ready=1: compute next PC, apply RAS update, and go to S_REQ.
- Control inputs are sampled only when instr_valid and instr_ready are both 1; they are ignored otherwise.
- Next-PC priority: ret -> RAS top; else branch or loadPC -> target; else pc+1 with wrap (2^ADDR_W-1 -> 0).
- push: writes pc+1 (wrapped) to RAS. With push and loadPC together (a call), PC <= target.
- push and ret together: next PC = old top, and the top entry is replaced with pc+1. Count is unchanged and no flag is set.
- Push when full (count=RAS_DEPTH): overwrite the oldest entry circularly, count stays at RAS_DEPTH, set ras_ovf.
- Ret when empty: next PC = RESET_PC, set ras_unf, count stays 0.
- ras_ovf and ras_unf are cleared only by rst.
- Latency: the handshake at cycle N gives imem_req=1 at N+1. With ack at N+1, instr_valid=1 at N+2. Throughput is at most one instruction per 2 cycles.
- instr_valid drops the cycle after the handshake. No bubble-free streaming.
- rst mid-fetch: an outstanding imem_ack arriving after reset is ignored in S_RST. The memory is required to tolerate an abandoned request.

Optional Feature:
FETCH_STATS_EN: when defined, adds two output ports.
- instr_count (32 bits): increments on every instr_valid and instr_ready handshake.
- redirect_count (16 bits): increments on every handshake with ret, branch or loadPC set.
- Both counters wrap, and both reset to 0 on rst.
- When the macro is undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, memory returns addr+16'h1000, ack same cycle, instr_ready=1 always -> instr 16'h1000, 16'h1001, 16'h1002 at 2-cycle spacing, imem_addr 0,1,2.
- Slow memory and backpressure: ack 3 cycles after req, instr_ready held 0 for 4 cycles -> imem_addr stable during the wait, instr and instr_valid stable until the handshake, no second request issued.
- Call/return: at pc=5, push+loadPC with target=0x20 -> next fetch at 0x20. At 0x22, ret -> next fetch at 6, RAS empty again, no flags set.
- RAS overflow/underflow: 9 consecutive calls with RAS_DEPTH=8 -> ras_ovf=1. 9 rets -> first 8 return in LIFO order (the oldest return address is lost). The 9th ret goes to RESET_PC and sets ras_unf=1.
- Wrap and priority: pc=0x3FF sequential -> next 0x000. Handshake with ret+branch, RAS top=0x10, target=0x40 -> next pc=0x10.
- Reset mid-fetch: rst asserted while in S_REQ with ack pending, then ack arrives during S_RST -> ignored. The first post-reset fetch is at RESET_PC, and instr_valid=0 until it completes.
